cassette_player: RTL

Tape-image playback engine for the cassette tutorial core. It fetches tape bytes from a byte-wide image memory through a request/acknowledge port and serialises them MSB-first as a pulse-width-coded cassette signal. It publishes the `pos`, `max` and `tape_data` values that the cassette overlay consumes to draw its progress bar, gear animation and level meter. It sits between the image buffer (ioctl/SDRAM side) and the emulated machine's cassette input.

---
 rtl/cassette_player.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cassette_player.sv
// cassette_player: fetches tape-image bytes through a req/ack port and plays them MSB-first as a pulse-width-coded signal.
// Optional build macro CASSETTE_MOTOR_EN adds a motor input that gates playback together with play.
module cassette_player #(
  parameter logic [15:0] CLK_DIV    = 16'd50,
  parameter logic [7:0]  ZERO_TICKS = 8'd4,
  parameter logic [7:0]  ONE_TICKS  = 8'd8
) (
  input  logic        i_clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        rewind,
  input  logic [24:0] tape_len,
  output logic        mem_rd,
  output logic [24:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
`ifdef CASSETTE_MOTOR_EN
  input  logic        motor,
`endif
  output logic        cas_out,
  output logic [24:0] pos,
  output logic [24:0] max,
  output logic [7:0]  tape_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY_HI, PLAY_LO, NEXT, DONE} state_t;
  typedef struct packed {
    logic       vld;
    logic [7:0] data;
  } fbuf_t;

  state_t      state, state_nx;
  fbuf_t       fbuf;
  logic [15:0] presc;
  logic [7:0]  tcnt;
  logic [7:0]  half_n;
  logic [2:0]  bit_idx;
  logic        run, in_play, tick, half_end, load;

`ifdef CASSETTE_MOTOR_EN
  assign run     = play && motor;
  assign cas_out = (state == PLAY_HI) && motor;
`else
  assign run     = play;
  assign cas_out = (state == PLAY_HI);
`endif

  assign in_play  = (state == PLAY_HI) || (state == PLAY_LO);
  assign tick     = run && in_play && (presc == CLK_DIV - 16'd1);
  assign half_n   = tape_data[bit_idx] ? ONE_TICKS : ZERO_TICKS;
  assign half_end = tick && (tcnt == half_n - 8'd1);
  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // pos is already bumped on entry to NEXT, so the end-of-tape test is pos==max here
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    if (rewind) state_nx = LOAD;
    else begin
      case (state)
        IDLE, DONE: state_nx = state;
        LOAD: begin
          if (max == '0) state_nx = DONE;
          else if (fbuf.vld) begin
            load     = 1'b1;
            state_nx = PLAY_HI;
          end
        end
        PLAY_HI: if (half_end) state_nx = PLAY_LO;
        PLAY_LO: if (half_end) state_nx = (bit_idx == 3'd0) ? NEXT : PLAY_HI;
        NEXT: begin
          if (pos == max) state_nx = DONE;
          else if (fbuf.vld) begin
            load     = 1'b1;
            state_nx = PLAY_HI;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      pos       <= '0;
      max       <= '0;
      tape_data <= '0;
      fbuf      <= '0;
      presc     <= '0;
      tcnt      <= '0;
      bit_idx   <= 3'd7;
    end else if (rewind) begin
      // abandons any outstanding read; an ack in this cycle is dropped
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      pos      <= '0;
      max      <= tape_len;
      fbuf.vld <= 1'b0;
      presc    <= '0;
      tcnt     <= '0;
      bit_idx  <= 3'd7;
    end else begin
      if (mem_rd && mem_ack) begin
        fbuf     <= '{vld: 1'b1, data: mem_data};
        mem_rd   <= 1'b0;
        mem_addr <= mem_addr + 25'd1;
      end else if (!mem_rd && !fbuf.vld && (mem_addr < max)) begin
        mem_rd <= 1'b1;
      end
      if (load) begin
        tape_data <= fbuf.data;
        fbuf.vld  <= 1'b0;
        bit_idx   <= 3'd7;
      end
      if (run && in_play) presc <= tick ? '0 : presc + 16'd1;
      if (half_end) begin
        tcnt <= '0;
        if (state == PLAY_LO) begin
          bit_idx <= bit_idx - 3'd1;
          if (bit_idx == 3'd0) pos <= pos + 25'd1;
        end
      end else if (tick) begin
        tcnt <= tcnt + 8'd1;
      end
    end
  end

endmodule
